// File: rtl/hpdcache_sram_rsp_pkg.sv
// Shared constants and types for the hpdcache SRAM request/response front end.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package hpdcache_sram_rsp_pkg;

  localparam int ADDR_SIZE_DEF  = 8;
  localparam int DATA_SIZE_DEF  = 256;
  localparam int FIFO_DEPTH_DEF = 2;

  // Pointer width for a FIFO of the given depth (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: must be able to hold the value 'depth' itself.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int PTR_W_DEF = ptr_width(FIFO_DEPTH_DEF);
  localparam int OCC_W_DEF = occ_width(FIFO_DEPTH_DEF);

  // One SRAM command as seen on the request interface.
  typedef struct packed {
    logic                     we;
    logic [ADDR_SIZE_DEF-1:0] addr;
    logic [DATA_SIZE_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/hpdcache_sram_rsp_fifo.sv
// In-order response FIFO with occupancy counter and wrapping pointers.
// Latency: a pushed word is visible at rdata the cycle after the push edge.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module hpdcache_sram_rsp_fifo
  import hpdcache_sram_rsp_pkg::*;
#(
  parameter int WIDTH = DATA_SIZE_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          pop,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [occ_width(DEPTH)-1:0]   occ
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; push+pop together leaves occ unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (push) wptr <= next_ptr(wptr);
      if (pop)  rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  assign full  = (occ == OCC_W'(DEPTH));
  assign empty = (occ == '0);
  // Head reads as zero when empty so the response bus is quiet when idle.
  assign rdata = empty ? '0 : mem[rptr];

  underflow_chk: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/hpdcache_sram_rsp_buf.sv
// Valid/ready front end for a 1RW SRAM with 1-cycle read latency; reads land in a response FIFO.
// Latency: read accepted in cycle N gives rsp_valid in N+2 (N+1 with HPDCACHE_SRAM_RSP_BYPASS_EN).
// Backpressure: req_ready is withheld once FIFO occupancy plus the in-flight read would exceed depth.
module hpdcache_sram_rsp_buf
  import hpdcache_sram_rsp_pkg::*;
#(
  parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [DATA_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_SIZE-1:0] rsp_rdata,
  output logic                 sram_cs,
  output logic                 sram_we,
  output logic [ADDR_SIZE-1:0] sram_addr,
  output logic [DATA_SIZE-1:0] sram_wdata,
  input  logic [DATA_SIZE-1:0] sram_rdata
);

  localparam int OCC_W = occ_width(FIFO_DEPTH);

  logic                 inflight;
  logic                 pop;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_rdata;
  logic [OCC_W-1:0]     fifo_occ;
  logic [OCC_W:0]       pending;
  logic                 credit_ok;

  assign pop = rsp_valid & rsp_ready;

  // Credit check: entries held plus the read in the SRAM pipe, minus this cycle's pop.
  always_comb begin
    pending   = {1'b0, fifo_occ} + {{OCC_W{1'b0}}, inflight} - {{OCC_W{1'b0}}, pop};
    credit_ok = (pending < (OCC_W + 1)'(FIFO_DEPTH));
  end

  assign req_ready = ~rst & credit_ok;

  // SRAM command is a direct pass-through, zeroed when not selected.
  assign sram_cs    = req_valid & req_ready;
  assign sram_we    = sram_cs & req_we;
  assign sram_addr  = sram_cs ? req_addr  : '0;
  assign sram_wdata = sram_cs ? req_wdata : '0;

  // Track the read whose data the SRAM returns next cycle; writes never count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= sram_cs & ~req_we;
  end

  // Steer returning read data either into the FIFO or straight to the consumer.
  always_comb begin
`ifdef HPDCACHE_SRAM_RSP_BYPASS_EN
    rsp_valid = ~fifo_empty | inflight;
    rsp_rdata = (fifo_empty & inflight) ? sram_rdata : fifo_rdata;
    fifo_push = inflight & ~(fifo_empty & rsp_ready);
    fifo_pop  = pop & ~fifo_empty;
`else
    rsp_valid = ~fifo_empty;
    rsp_rdata = fifo_rdata;
    fifo_push = inflight;
    fifo_pop  = pop;
`endif
  end

  hpdcache_sram_rsp_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (sram_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .occ   (fifo_occ)
  );

  overflow_chk: assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full));

endmodule

// File: doc/hpdcache_sram_rsp_buf.md
Name: hpdcache_sram_rsp_buf

Overview:
Request/response front end for one single-port (1RW) behavioural SRAM macro wrapper, which has 1-cycle read latency and no backpressure.
- Accepts read/write requests on a valid/ready interface and drives the SRAM cs/we/addr/wdata directly.
- Captures read data returned one cycle later into a small response FIFO, presented on a valid/ready interface.
- Credit accounting guarantees the SRAM never returns data the FIFO cannot hold.
- Sits between the hpdcache data/directory controllers and the SRAM wrapper instance.

Parameters:
ADDR_SIZE, 8, SRAM address width; matches wrapper addr.
DATA_SIZE, 256, SRAM word width; matches wrapper wdata/rdata.
FIFO_DEPTH, 2, response FIFO entries; must be >= 2.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-high.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when valid & ready.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_SIZE  word address.
req_wdata  in  DATA_SIZE  write data.
rsp_valid  out  1  read response valid.
rsp_ready  in  1  consumer accepts response.
rsp_rdata  out  DATA_SIZE  read data.
sram_cs  out  1  SRAM chip select.
sram_we  out  1  SRAM write enable.
sram_addr  out  ADDR_SIZE  SRAM address.
sram_wdata  out  DATA_SIZE  SRAM write data.
sram_rdata  in  DATA_SIZE  SRAM read data, valid the cycle after a read with cs=1.

Behaviour:
- Reset is asynchronous, active-high, with one clock `clk`.
  - While rst=1: req_ready=0, rsp_valid=0, sram_cs=0, FIFO occupancy=0, inflight=0, rsp_rdata=0.
- SRAM side is combinational from the request side:
  - sram_cs = req_valid & req_ready.
  - sram_we = req_we.
  - sram_addr = req_addr.
  - sram_wdata = req_wdata.
  - When sram_cs=0, we/addr/wdata are don't-care; the implementation drives them 0.
- Credit rule:
  - inflight is a 1-bit register = (previous-cycle accepted read).
  - pop = rsp_valid & rsp_ready.
  - req_ready = (occ + inflight - pop) < FIFO_DEPTH. This is a combinational path from rsp_ready to req_ready.
  - Applies to writes too; there is no separate write bypass.
- Read latency: request accepted at cycle N → sram_rdata sampled at edge N+1 into the FIFO → rsp_valid=1 in cycle N+2.
- Writes generate no response and do not set inflight.
- FIFO is in-order, with occ counter 0..FIFO_DEPTH and wrapping read/write pointers.
  - Simultaneous push and pop: occ unchanged; both pointers advance.
  - Pop when empty cannot occur, since rsp_valid=0.
  - Push when full cannot occur by the credit rule; an assertion checks this.
- rsp_rdata and rsp_valid must stay stable while rsp_valid & !rsp_ready.
- Sustained throughput: one read per cycle when rsp_ready is held 1.
- Reset mid-operation: in-flight read is discarded, FIFO is flushed, and no spurious response appears after rst deasserts.

Optional Feature:
Macro HPDCACHE_SRAM_RSP_BYPASS_EN.
- Defined: when the FIFO is empty and inflight=1, rsp_valid=1 and rsp_rdata=sram_rdata in cycle N+1.
  - If popped that cycle, nothing is pushed.
  - Otherwise the data is pushed and held.
  - Read latency becomes 1.
- Undefined: all read data is registered in the FIFO; latency is 2.

Decomposition:
- Package hpdcache_sram_rsp_pkg:
  - ptr/occupancy width constants derived via $clog2(FIFO_DEPTH).
  - Request struct typedef {we, addr, wdata} parameterised via localparams.
- One sub-module: hpdcache_sram_rsp_fifo.
  - Generic synchronous FIFO with push/pop, full/empty and occ outputs, async active-high reset.
  - Instantiated once.

Test Plan:
- Write addr 0x10 data 0xA5.., then read 0x10 with rsp_ready=1 → sram_cs pulses twice; rsp_valid at read cycle+2 (+1 with BYPASS) with rsp_rdata 0xA5...
- rsp_ready=0, issue 3 back-to-back reads (addrs 1,2,3) → first two accepted; req_ready=0 on the 3rd until rsp_ready=1; responses return in order 1,2,3; no data lost.
- 32 consecutive reads with rsp_ready=1 → req_ready stays 1; exactly 32 responses, one per cycle, in order.
- Read accepted, rst asserted the next cycle for 2 cycles → rsp_valid=0, req_ready=0 during reset; no response after release; occ=0.
- Random rsp_ready (50%) over 1000 mixed reads/writes against a reference memory model → all read data matches; FIFO overflow assertion never fires; rsp stable under stall.
